module_alu_param: RTL and testbench

Parametrised, registered ALU for the lab datapath. It generalises the single-function logic-unit blocks into one unit with:
- operand width set by `WIDTH`
- a 4-bit operation select covering logic, arithmetic and shift ops
- full N/Z/C/V flag generation
- a start/done handshake

Logic and arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle, under a small FSM. It sits between the operand registers and the result/flag write-back of the lab datapath.

---
 rtl/module_alu_param.sv | 159 +++++++++++++++
 tb/tb_module_alu_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/module_alu_param.sv
// Parametrised registered ALU: single-cycle logic/arithmetic ops, iterative
// one-bit-per-cycle shifts, N/Z/C/V flags and a start/done handshake.
module module_alu_param #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] ALUA_i,
    input  logic [WIDTH-1:0] ALUB_i,
    input  logic [3:0]       ALUControl_i,
    input  logic             ALUFlagIn_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] ALUResult_o,
    output logic [3:0]       ALUFlags_o
);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_INC = 4'd3;
    localparam logic [3:0] OP_DEC = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic logic [3:0] make_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] work_p1;
    logic             shl_p1;
    logic             fill_p1;

    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] res_c;
    logic             c_c;
    logic             v_c;
    logic             illegal_c;
    logic [3:0]       flags_c;
    logic             is_shift;
    logic [WIDTH-1:0] k_c;
    logic [WIDTH-1:0] step_val;
    logic             step_out;

    assign ready_o  = (state == IDLE);
    assign is_shift = (ALUControl_i == OP_SLL) || (ALUControl_i == OP_SRL);
    assign k_c      = (ALUB_i >= WIDTH_V) ? WIDTH_V : ALUB_i;

    // Subtraction and decrement reuse the adder as A + ~B + 1.
    always_comb begin
        add_b   = ALUB_i;
        add_cin = 1'b0;
        case (ALUControl_i)
            OP_INC: begin add_b = '0;      add_cin = 1'b1; end
            OP_DEC: begin add_b = ~ONE_V;  add_cin = 1'b1; end
            OP_SUB: begin add_b = ~ALUB_i; add_cin = 1'b1; end
            default: ;
        endcase
        sum = {1'b0, ALUA_i} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        ovf = (ALUA_i[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != ALUA_i[WIDTH-1]);
    end

    always_comb begin
        res_c     = '0;
        c_c       = 1'b0;
        v_c       = 1'b0;
        illegal_c = 1'b0;
        case (ALUControl_i)
            OP_AND: res_c = ALUA_i & ALUB_i;
            OP_OR:  res_c = ALUA_i | ALUB_i;
            OP_XOR: res_c = ALUA_i ^ ALUB_i;
            OP_NOT: res_c = ~ALUA_i;
            OP_ADD, OP_INC, OP_DEC, OP_SUB: begin
                res_c = sum[WIDTH-1:0];
                c_c   = sum[WIDTH];
                v_c   = ovf;
            end
            OP_SLL, OP_SRL: res_c = ALUA_i;
            default: illegal_c = 1'b1;
        endcase
        flags_c = illegal_c ? 4'b0100 : make_flags(res_c, c_c, v_c);
    end

    always_comb begin
        if (shl_p1) begin
            step_val = {work_p1[WIDTH-2:0], fill_p1};
            step_out = work_p1[WIDTH-1];
        end else begin
            step_val = {fill_p1, work_p1[WIDTH-1:1]};
            step_out = work_p1[0];
        end
    end

    // Stage p1: shift working register, loaded at accept and stepped in SHIFT
    always_ff @(posedge clk_i) begin
        if (state == IDLE) begin
            if (start_i && is_shift) begin
                work_p1 <= ALUA_i;
                shl_p1  <= (ALUControl_i == OP_SLL);
                fill_p1 <= ALUFlagIn_i;
            end
        end else begin
            work_p1 <= step_val;
        end
    end

    // Control and registered result/flag write-back
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            cnt         <= '0;
            done_o      <= 1'b0;
            ALUResult_o <= '0;
            ALUFlags_o  <= 4'b0000;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (is_shift && (k_c != '0)) begin
                            cnt   <= k_c;
                            state <= SHIFT;
                        end else begin
                            ALUResult_o <= res_c;
                            ALUFlags_o  <= flags_c;
                            done_o      <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    cnt <= cnt - ONE_V;
                    if (cnt == ONE_V) begin
                        ALUResult_o <= step_val;
                        ALUFlags_o  <= make_flags(step_val, step_out, 1'b0);
                        done_o      <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_module_alu_param.sv
// Bench for module_alu_param (WIDTH=4): directed vectors with literal
// expectations plus an arithmetic reference model checked every cycle.
module tb_module_alu_param;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int MAXS = (1 << (W - 1)) - 1;
    localparam int MINS = -(1 << (W - 1));

    localparam logic [3:0] C_AND = 4'd0, C_OR = 4'd1, C_ADD = 4'd2, C_INC = 4'd3;
    localparam logic [3:0] C_DEC = 4'd4, C_NOT = 4'd5, C_SUB = 4'd6, C_XOR = 4'd7;
    localparam logic [3:0] C_SLL = 4'd8, C_SRL = 4'd9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic [3:0]   ctrl;
    logic         fill;
    logic         ready, done;
    logic [W-1:0] res;
    logic [3:0]   flags;

    always #5 clk = ~clk;

    module_alu_param #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .ALUA_i      (a),
        .ALUB_i      (b),
        .ALUControl_i(ctrl),
        .ALUFlagIn_i (fill),
        .ready_o     (ready),
        .done_o      (done),
        .ALUResult_o (res),
        .ALUFlags_o  (flags)
    );

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v > MAXS) ? v - (1 << W) : v;
    endfunction

    // Reference: result, flags and shift count straight from the operation rules.
    function automatic void model(input logic [3:0] c, input logic [W-1:0] av,
                                  input logic [W-1:0] bv, input logic f,
                                  output logic [3:0] r, output logic [3:0] fl,
                                  output int k);
        int ai, bi, rv, sv;
        bit cc, vv;
        ai = int'(av);
        bi = int'(bv);
        rv = 0; sv = 0; cc = 0; vv = 0; k = 0;
        case (c)
            C_AND: rv = ai & bi;
            C_OR:  rv = ai | bi;
            C_XOR: rv = ai ^ bi;
            C_NOT: rv = (~ai) & MASK;
            C_ADD: begin
                rv = (ai + bi) & MASK; cc = (ai + bi) > MASK;
                sv = to_signed(ai) + to_signed(bi); vv = (sv > MAXS) || (sv < MINS);
            end
            C_INC: begin
                rv = (ai + 1) & MASK; cc = (ai + 1) > MASK;
                sv = to_signed(ai) + 1; vv = sv > MAXS;
            end
            C_SUB: begin
                rv = (ai - bi) & MASK; cc = ai >= bi;
                sv = to_signed(ai) - to_signed(bi); vv = (sv > MAXS) || (sv < MINS);
            end
            C_DEC: begin
                rv = (ai - 1) & MASK; cc = ai >= 1;
                sv = to_signed(ai) - 1; vv = sv < MINS;
            end
            C_SLL: begin
                k  = (bi < W) ? bi : W;
                rv = ((ai << k) | (f ? ((1 << k) - 1) : 0)) & MASK;
                cc = (k > 0) ? ((ai >> (W - k)) & 1) != 0 : 1'b0;
            end
            C_SRL: begin
                k  = (bi < W) ? bi : W;
                rv = (ai >> k) | (f ? (MASK & ~(MASK >> k)) : 0);
                cc = (k > 0) ? ((ai >> (k - 1)) & 1) != 0 : 1'b0;
            end
            default: begin
                r = 4'h0; fl = 4'b0100;
                return;
            end
        endcase
        r  = 4'(rv);
        fl = {r[W-1], (rv == 0), cc, vv};
    endfunction

    int         m_rem = 0;
    logic [3:0] m_res = '0, m_flags = '0, p_res = '0, p_flags = '0;
    logic       m_done = 1'b0;

    always @(posedge clk) begin : ref_model
        logic [3:0] r, fl;
        int k;
        if (!rst_n) begin
            m_rem = 0; m_res = '0; m_flags = '0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_res = p_res; m_flags = p_flags; m_done = 1'b1;
                end
            end else if (start) begin
                model(ctrl, a, b, fill, r, fl, k);
                if (k == 0) begin
                    m_res = r; m_flags = fl; m_done = 1'b1;
                end else begin
                    m_rem = k; p_res = r; p_flags = fl;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", ready, (m_rem == 0));
            chk("done", done, m_done);
            chk("result", res, m_res);
            chk("flags", flags, m_flags);
        end
    end

    task automatic run_op(input string name, input logic [3:0] c, input logic [3:0] av,
                          input logic [3:0] bv, input logic f, input logic [3:0] er,
                          input logic [3:0] ef, input int ek, input bit poke);
        int lat;
        @(negedge clk);
        ctrl = c; a = av; b = bv; fill = f; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av; b = ~bv; ctrl = c ^ 4'h1; fill = ~f;
        lat = 1;
        chk({name, "_ready"}, ready, (ek == 0));
        if (poke && done !== 1'b1) begin
            start = 1'b1; ctrl = C_OR;
        end
        while (done !== 1'b1 && lat < 3 * W) begin
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        start = 1'b0;
        chk({name, "_done"}, done, 1);
        chk({name, "_lat"}, lat, (ek == 0) ? 1 : ek + 1);
        chk({name, "_res"}, res, er);
        chk({name, "_flags"}, flags, ef);
    endtask

    logic [3:0] bb_c [7] = '{C_AND, C_XOR, C_NOT, C_INC, C_DEC, 4'd13, C_ADD};
    logic [3:0] bb_a [7] = '{4'hC, 4'h6, 4'h0, 4'hF, 4'h8, 4'h5, 4'h9};
    logic [3:0] bb_b [7] = '{4'hA, 4'h6, 4'h3, 4'h2, 4'h1, 4'h5, 4'h9};

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; ctrl = '0; fill = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_res", res, 0);
        chk("rst_flags", flags, 0);

        // reset wins over a simultaneous request
        ctrl = C_OR; a = 4'hA; b = 4'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_prio_done", done, 0);
        chk("rst_prio_res", res, 0);
        rst_n = 1'b1;

        run_op("or",      C_OR,  4'hA, 4'h5, 1'b0, 4'hF, 4'b1000, 0, 1'b0);
        run_op("add_ovf", C_ADD, 4'h7, 4'h1, 1'b0, 4'h8, 4'b1001, 0, 1'b0);
        run_op("add_cy",  C_ADD, 4'hF, 4'h1, 1'b0, 4'h0, 4'b0110, 0, 1'b0);
        run_op("sub_eq",  C_SUB, 4'h3, 4'h3, 1'b0, 4'h0, 4'b0110, 0, 1'b0);
        run_op("sub_brw", C_SUB, 4'h2, 4'h5, 1'b0, 4'hD, 4'b1000, 0, 1'b0);
        run_op("inc",     C_INC, 4'h7, 4'h0, 1'b0, 4'h8, 4'b1001, 0, 1'b0);
        run_op("dec0",    C_DEC, 4'h0, 4'h0, 1'b0, 4'hF, 4'b1000, 0, 1'b0);
        run_op("dec8",    C_DEC, 4'h8, 4'h0, 1'b0, 4'h7, 4'b0011, 0, 1'b0);
        run_op("not",     C_NOT, 4'h5, 4'h0, 1'b0, 4'hA, 4'b1000, 0, 1'b0);
        run_op("xor",     C_XOR, 4'hF, 4'hF, 1'b0, 4'h0, 4'b0100, 0, 1'b0);
        run_op("and",     C_AND, 4'hC, 4'hA, 1'b0, 4'h8, 4'b1000, 0, 1'b0);
        run_op("sll2",    C_SLL, 4'h9, 4'h2, 1'b0, 4'h4, 4'b0000, 2, 1'b1);
        run_op("srl7",    C_SRL, 4'h8, 4'h7, 1'b1, 4'hF, 4'b1010, 4, 1'b0);
        run_op("illegal", 4'd12, 4'h8, 4'h7, 1'b1, 4'h0, 4'b0100, 0, 1'b0);
        run_op("sll0",    C_SLL, 4'h3, 4'h0, 1'b1, 4'h3, 4'b0000, 0, 1'b0);
        run_op("sllF",    C_SLL, 4'h1, 4'hF, 1'b0, 4'h0, 4'b0110, 4, 1'b1);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i > 0) chk("b2b_done", done, 1);
            ctrl = bb_c[i]; a = bb_a[i]; b = bb_b[i]; fill = 1'b0; start = 1'b1;
        end
        @(negedge clk);
        chk("b2b_last_done", done, 1);
        start = 1'b0;
        @(negedge clk);

        // reset arriving on the second shift edge drops the operation
        ctrl = C_SRL; a = 4'h8; b = 4'h4; fill = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_busy", ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_res", res, 0);
        chk("mid_rst_flags", flags, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", done, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_no_done", done, 0);
        end
        run_op("or_after", C_OR, 4'hA, 4'h5, 1'b0, 4'hF, 4'b1000, 0, 1'b0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
